// File: rtl/spi_slave_shift_engine_pkg.sv
// Shared definitions for the SPI slave shift engine: frame state encoding,
// SPI mode constants ({cpol,cpha}), default idle fill bit, counter sizing.
package spi_slave_shift_engine_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   // SPI modes as {cpol, cpha}
   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   // Bit replicated to form the default word sent when nothing is queued
   localparam logic DEFAULT_IDLE_BIT = 1'b1;

   // Number of bits needed to count 0..value-1 (value >= 2)
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/spi_slave_shift_engine_tx_holding.sv
// One-deep TX holding register. The writer side is a valid/ready handshake;
// the shift engine pulls a word with 'load'. When the register is empty and
// a write arrives in the same cycle as a load, the word bypasses straight to
// the shift register and the holding register stays empty.
module spi_tx_holding #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [N-1:0] wr_data,
   input  logic         wr_valid,
   output logic         wr_ready,
   input  logic         load,
   output logic         load_hit,
   output logic [N-1:0] load_data
);

   logic         full_reg;
   logic [N-1:0] data_reg;
   logic         accept;

   assign wr_ready = ~full_reg;
   assign accept   = wr_valid & ~full_reg;

   // Word offered to the shift engine: stored word first, else a bypassing write
   always_comb begin
      load_hit  = 1'b0;
      load_data = data_reg;
      if (full_reg) begin
         load_hit  = 1'b1;
         load_data = data_reg;
      end else if (accept) begin
         load_hit  = 1'b1;
         load_data = wr_data;
      end
   end

   // Occupancy: a load empties the register; an accept not consumed by a load fills it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         full_reg <= 1'b0;
         data_reg <= '0;
      end else if (load) begin
         full_reg <= 1'b0;
      end else if (accept) begin
         full_reg <= 1'b1;
         data_reg <= wr_data;
      end
   end

endmodule

// File: rtl/spi_slave_shift_engine.sv
// SPI slave shift engine: separate RX/TX shift registers driven by
// synchronised SCLK edge strobes, multi-word bursts per chip-select window,
// runtime CPOL/CPHA and bit order latched at the start of each frame.
module spi_slave_shift_engine
   import spi_slave_shift_engine_pkg::*;
#(
   parameter int           N            = 8,
   parameter int           WCW          = 8,
   parameter logic [N-1:0] IDLE_PATTERN = {N{DEFAULT_IDLE_BIT}}
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           sel,
   input  logic           rising,
   input  logic           falling,
   input  logic           si,
   output logic           so,
   input  logic           cpol,
   input  logic           cpha,
   input  logic           lsb_first,
   input  logic [N-1:0]   tx_data,
   input  logic           tx_valid,
   output logic           tx_ready,
   output logic [N-1:0]   rx_data,
   output logic           rx_valid,
   output logic [WCW-1:0] word_count,
   output logic           busy,
   output logic           tx_underrun,
   output logic           frame_abort
);

   localparam int CW = clog2(N);

   state_t         state_reg;
   logic           sel_d_reg;
   logic           cpol_reg;
   logic           cpha_reg;
   logic           lsb_reg;
   logic           abort_reg;

   logic [N-1:0]   tx_sr_reg;
   logic [CW-1:0]  tx_cnt_reg;
   logic           underrun_reg;

   logic [N-1:0]   rx_sr_reg;
   logic [CW-1:0]  rx_cnt_reg;
   logic [N-1:0]   rx_data_reg;
   logic           rx_valid_reg;
   logic [WCW-1:0] word_count_reg;

   logic           sel_rise;
   logic           sel_fall;
   logic           frame_start;
   logic           frame_end;
   logic           edge_ok;
   logic           sample_raw;
   logic           shift_raw;
   logic           sample_edge;
   logic           shift_edge;
   logic           tx_load;
   logic           load_hit;
   logic [N-1:0]   load_data;
   logic [N-1:0]   rx_assembled;

   assign sel_rise    = sel & ~sel_d_reg;
   assign sel_fall    = ~sel & sel_d_reg;
   assign frame_start = (state_reg == ST_IDLE) & sel_rise;
   assign frame_end   = (state_reg == ST_ACTIVE) & sel_fall;

   // Strobes only count inside an active frame, and a simultaneous
   // rising+falling pair is a protocol error that is dropped entirely.
   assign edge_ok = (state_reg == ST_ACTIVE) & ~sel_fall & (rising ^ falling);

   // Map SCLK strobes onto sample/shift events for the latched mode
   always_comb begin
      sample_raw = 1'b0;
      shift_raw  = 1'b0;
      case ({cpol_reg, cpha_reg})
         MODE0: begin sample_raw = rising;  shift_raw = falling; end
         MODE1: begin sample_raw = falling; shift_raw = rising;  end
         MODE2: begin sample_raw = falling; shift_raw = rising;  end
         MODE3: begin sample_raw = rising;  shift_raw = falling; end
         default: begin sample_raw = 1'b0;  shift_raw = 1'b0;    end
      endcase
   end

   assign sample_edge = edge_ok & sample_raw;
   assign shift_edge  = edge_ok & shift_raw;

   // CPHA=0 presents the first bit before any clock edge, so it loads at
   // frame start and at the end of each word; CPHA=1 loads on the first
   // shift edge of each word.
   assign tx_load = (frame_start & ~cpha)
                  | (shift_edge & (cpha_reg ? (tx_cnt_reg == '0)
                                            : (tx_cnt_reg == CW'(N - 1))));

   assign rx_assembled = lsb_reg ? {si, rx_sr_reg[N-1:1]} : {rx_sr_reg[N-2:0], si};

   spi_tx_holding #(
      .N(N)
   ) u_tx_holding (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_data  (tx_data),
      .wr_valid (tx_valid),
      .wr_ready (tx_ready),
      .load     (tx_load),
      .load_hit (load_hit),
      .load_data(load_data)
   );

   // Frame state machine: mode latch at sel rise, abort detection at sel fall
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= ST_IDLE;
         sel_d_reg <= 1'b0;
         cpol_reg  <= 1'b0;
         cpha_reg  <= 1'b0;
         lsb_reg   <= 1'b0;
         abort_reg <= 1'b0;
      end else begin
         sel_d_reg <= sel;
         abort_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (sel_rise) begin
                  state_reg <= ST_ACTIVE;
                  cpol_reg  <= cpol;
                  cpha_reg  <= cpha;
                  lsb_reg   <= lsb_first;
               end
            end
            ST_ACTIVE: begin
               if (sel_fall) begin
                  state_reg <= ST_IDLE;
                  abort_reg <= (rx_cnt_reg != '0);
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // TX path: load from holding register (or idle fill) at load points, else shift
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_sr_reg    <= '0;
         tx_cnt_reg   <= '0;
         underrun_reg <= 1'b0;
      end else begin
         if (frame_start) begin
            tx_cnt_reg   <= '0;
            underrun_reg <= 1'b0;
         end else if (shift_edge) begin
            tx_cnt_reg <= (tx_cnt_reg == CW'(N - 1)) ? '0 : tx_cnt_reg + CW'(1);
         end
         if (tx_load) begin
            if (load_hit) begin
               tx_sr_reg <= load_data;
            end else begin
               tx_sr_reg    <= IDLE_PATTERN;
               underrun_reg <= 1'b1;
            end
         end else if (shift_edge) begin
            tx_sr_reg <= lsb_reg ? (tx_sr_reg >> 1) : (tx_sr_reg << 1);
         end
      end
   end

   // RX path: assemble bits on sample edges, publish each complete word
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_sr_reg      <= '0;
         rx_cnt_reg     <= '0;
         rx_data_reg    <= '0;
         rx_valid_reg   <= 1'b0;
         word_count_reg <= '0;
      end else begin
         rx_valid_reg <= 1'b0;
         if (frame_start) begin
            rx_cnt_reg     <= '0;
            word_count_reg <= '0;
         end else if (frame_end) begin
            rx_cnt_reg <= '0;
         end else if (sample_edge) begin
            rx_sr_reg <= rx_assembled;
            if (rx_cnt_reg == CW'(N - 1)) begin
               rx_cnt_reg   <= '0;
               rx_data_reg  <= rx_assembled;
               rx_valid_reg <= 1'b1;
               if (word_count_reg != {WCW{1'b1}}) begin
                  word_count_reg <= word_count_reg + WCW'(1);
               end
            end else begin
               rx_cnt_reg <= rx_cnt_reg + CW'(1);
            end
         end
      end
   end

   assign so          = (state_reg == ST_ACTIVE) ? (lsb_reg ? tx_sr_reg[0] : tx_sr_reg[N-1]) : 1'b0;
   assign busy        = (state_reg == ST_ACTIVE);
   assign rx_data     = rx_data_reg;
   assign rx_valid    = rx_valid_reg;
   assign word_count  = word_count_reg;
   assign tx_underrun = underrun_reg;
   assign frame_abort = abort_reg;

endmodule

// File: tb/tb_spi_slave_shift_engine.sv
// Bench for spi_slave_shift_engine: a bit-level SPI master drives strobes,
// a frame-level reference model predicts every output each cycle, and
// directed tests pin the model with hand-computed words.
module tb_spi_slave_shift_engine;

   localparam int N   = 8;
   localparam int WCW = 8;
   localparam logic [N-1:0] IDLE_W = 8'hFF;

   logic           clk = 1'b0;
   logic           reset_n = 1'b1;
   logic           sel = 1'b0, rising = 1'b0, falling = 1'b0, si = 1'b0;
   logic           cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
   logic [N-1:0]   tx_data = '0;
   logic           tx_valid = 1'b0;
   logic           so, tx_ready, rx_valid, busy, tx_underrun, frame_abort;
   logic [N-1:0]   rx_data;
   logic [WCW-1:0] word_count;

   int checks = 0;
   int errors = 0;
   int rxv_cnt = 0;
   bit chk_en = 1'b0;

   spi_slave_shift_engine #(.N(N), .WCW(WCW)) dut (
      .clk(clk), .reset_n(reset_n), .sel(sel), .rising(rising), .falling(falling),
      .si(si), .so(so), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .word_count(word_count),
      .busy(busy), .tx_underrun(tx_underrun), .frame_abort(frame_abort)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (frame/word level) ----------------
   bit           m_active = 0, m_sel_d = 0, m_cpol = 0, m_cpha = 0, m_lsb = 0;
   bit           m_hold_full = 0;
   logic [N-1:0] m_hold_data = '0;
   logic [N-1:0] m_tx_word = '0;    // word most recently loaded for transmit
   int           m_shifted = 0;     // bits shifted out of it since load
   int           m_tx_cnt = 0;      // shift edges in frame, modulo N
   logic         m_rxq[$];          // bits of the word being received, in arrival order
   logic [N-1:0] m_rx_data = '0;
   bit           m_rx_valid = 0, m_underrun = 0, m_abort = 0;
   int           m_wc = 0;

   function automatic logic m_so();
      if (m_shifted >= N) return 1'b0;
      return m_lsb ? m_tx_word[m_shifted] : m_tx_word[N-1-m_shifted];
   endfunction

   function automatic bit m_is_sample(input logic r, input logic f);
      logic lead;
      lead = m_cpol ? f : r;
      return m_cpha ? !lead : lead;
   endfunction

   task automatic model_step();
      bit rise_s, fall_s, acc, ld;
      logic [N-1:0] w;
      if (!reset_n) begin
         m_active = 0; m_sel_d = 0; m_cpol = 0; m_cpha = 0; m_lsb = 0;
         m_hold_full = 0; m_hold_data = '0; m_tx_word = '0; m_shifted = 0;
         m_tx_cnt = 0; m_rxq.delete(); m_rx_data = '0; m_rx_valid = 0;
         m_underrun = 0; m_abort = 0; m_wc = 0;
         return;
      end
      rise_s = sel && !m_sel_d;
      fall_s = !sel && m_sel_d;
      acc = tx_valid && !m_hold_full;
      ld = 0;
      m_rx_valid = 0;
      m_abort = 0;
      if (!m_active) begin
         if (rise_s) begin
            m_active = 1; m_cpol = cpol; m_cpha = cpha; m_lsb = lsb_first;
            m_tx_cnt = 0; m_rxq.delete(); m_wc = 0; m_underrun = 0;
            ld = !cpha;
         end
      end else if (fall_s) begin
         if (m_rxq.size() != 0) m_abort = 1;
         m_rxq.delete();
         m_active = 0;
      end else if (rising != falling) begin
         if (m_is_sample(rising, falling)) begin
            m_rxq.push_back(si);
            if (m_rxq.size() == N) begin
               w = '0;
               for (int k = 0; k < N; k++) w[m_lsb ? k : N-1-k] = m_rxq[k];
               m_rx_data = w;
               m_rx_valid = 1;
               if (m_wc < (1 << WCW) - 1) m_wc++;
               m_rxq.delete();
            end
         end else begin
            if (m_cpha ? (m_tx_cnt == 0) : (m_tx_cnt == N-1)) ld = 1;
            else m_shifted++;
            m_tx_cnt = (m_tx_cnt + 1) % N;
         end
      end
      if (ld) begin
         m_shifted = 0;
         if (m_hold_full) begin
            m_tx_word = m_hold_data; m_hold_full = 0;
         end else if (acc) begin
            m_tx_word = tx_data; acc = 0;
         end else begin
            m_tx_word = IDLE_W; m_underrun = 1;
         end
      end
      if (acc) begin
         m_hold_full = 1; m_hold_data = tx_data;
      end
      m_sel_d = sel;
   endtask

   initial forever begin
      @(posedge clk or negedge reset_n);
      model_step();
   end

   // Compare process: all outputs every cycle; so whenever the master samples it
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("busy", busy, m_active);
         chk("tx_ready", tx_ready, !m_hold_full);
         chk("rx_data", rx_data, m_rx_data);
         chk("rx_valid", rx_valid, m_rx_valid);
         chk("word_count", word_count, m_wc);
         chk("tx_underrun", tx_underrun, m_underrun);
         chk("frame_abort", frame_abort, m_abort);
         if (!m_active) chk("so_idle", so, 1'b0);
         else if ((rising != falling) && !(!sel && m_sel_d) && m_is_sample(rising, falling))
            chk("so_bit", so, m_so());
      end
   end

   initial forever begin
      @(negedge clk);
      if (rx_valid === 1'b1) rxv_cnt++;
   end

   // ---------------- SPI master ----------------
   task automatic strobe(input logic is_rise, output logic seen);
      rising = is_rise;
      falling = !is_rise;
      @(negedge clk);
      seen = so;
      @(posedge clk); #1;
      rising = 0;
      falling = 0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic xfer_bit(input logic mbit, output logic sbit);
      logic lead_rise, d;
      lead_rise = !cpol;
      if (!cpha) begin
         si = mbit;
         strobe(lead_rise, sbit);
         strobe(!lead_rise, d);
      end else begin
         strobe(lead_rise, d);
         si = mbit;
         strobe(!lead_rise, sbit);
      end
   endtask

   task automatic xfer_word(input logic [N-1:0] mw, output logic [N-1:0] sw);
      logic b;
      int idx;
      sw = '0;
      for (int i = 0; i < N; i++) begin
         idx = lsb_first ? i : N-1-i;
         xfer_bit(mw[idx], b);
         sw[idx] = b;
      end
   endtask

   task automatic write_when_ready(input logic [N-1:0] w);
      int n;
      n = 0;
      while (n < 2000) begin
         @(negedge clk);
         if (tx_ready === 1'b1) break;
         n++;
      end
      if (n >= 2000) begin
         checks++;
         errors++;
         $display("FAIL wr_timeout: actual=tx_ready_low required=tx_ready_high");
      end
      tx_data = w;
      tx_valid = 1;
      @(posedge clk); #1;
      tx_valid = 0;
   endtask

   task automatic start_frame(input logic pol, input logic pha, input logic lsb);
      cpol = pol; cpha = pha; lsb_first = lsb;
      sel = 1;
      @(posedge clk); #1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic end_frame();
      sel = 0;
      @(posedge clk); #1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   // ---------------- directed tests ----------------
   initial begin
      logic [N-1:0] sw, sw1, sw2, sw3;
      logic b;
      #2 reset_n = 0;
      chk_en = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx_ready", tx_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      reset_n = 1;
      repeat (2) @(posedge clk);
      #1;

      // 1: reset mid-frame with a word sitting in the holding register
      write_when_ready(8'h77);
      start_frame(0, 0, 0);
      write_when_ready(8'h66);
      for (int i = 0; i < 3; i++) xfer_bit(1'b1, b);
      chk("t1_ready_before", tx_ready, 1'b0);
      reset_n = 0;
      @(negedge clk);
      chk("t1_so", so, 1'b0);
      chk("t1_tx_ready", tx_ready, 1'b1);
      chk("t1_rx_data", rx_data, 8'h00);
      chk("t1_wc", word_count, 8'd0);
      chk("t1_busy", busy, 1'b0);
      sel = 0;
      @(posedge clk); #1;
      reset_n = 1;
      repeat (2) @(posedge clk);
      #1;

      // 2: mode 0 MSB-first single word
      write_when_ready(8'hA5);
      start_frame(0, 0, 0);
      rxv_cnt = 0;
      xfer_word(8'h3C, sw);
      chk("t2_so_word", sw, 8'hA5);
      chk("t2_rx_data", rx_data, 8'h3C);
      chk("t2_rxv_cnt", rxv_cnt, 1);
      chk("t2_wc", word_count, 8'd1);
      end_frame();

      // 3: mode 3 LSB-first three-word burst, writes follow tx_ready
      write_when_ready(8'h01);
      start_frame(1, 1, 1);
      rxv_cnt = 0;
      fork
         begin
            write_when_ready(8'h80);
            write_when_ready(8'hFF);
         end
         begin
            xfer_word(8'h11, sw1);
            xfer_word(8'h22, sw2);
            xfer_word(8'h35, sw3);
         end
      join
      chk("t3_so_w1", sw1, 8'h01);
      chk("t3_so_w2", sw2, 8'h80);
      chk("t3_so_w3", sw3, 8'hFF);
      chk("t3_rxv_cnt", rxv_cnt, 3);
      chk("t3_wc", word_count, 8'd3);
      chk("t3_rx_data", rx_data, 8'h35);
      chk("t3_underrun", tx_underrun, 1'b0);
      end_frame();

      // 4: holding empty at the second load point
      write_when_ready(8'h96);
      start_frame(0, 0, 0);
      xfer_word(8'h12, sw1);
      xfer_word(8'h34, sw2);
      chk("t4_so_w1", sw1, 8'h96);
      chk("t4_so_w2", sw2, 8'hFF);
      chk("t4_underrun", tx_underrun, 1'b1);
      end_frame();
      chk("t4_underrun_idle", tx_underrun, 1'b1);

      // 6: write in the same cycle as the sel-rise load with holding empty
      cpol = 0; cpha = 0; lsb_first = 0;
      tx_data = 8'hC9;
      tx_valid = 1;
      sel = 1;
      @(posedge clk); #1;
      tx_valid = 0;
      chk("t6_tx_ready", tx_ready, 1'b1);
      chk("t6_underrun_clr", tx_underrun, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      xfer_word(8'hE7, sw);
      chk("t6_so_word", sw, 8'hC9);
      chk("t6_rx_data", rx_data, 8'hE7);
      end_frame();

      // 5: abort after one word plus 5 bits, with an ignored double strobe
      start_frame(0, 1, 0);
      xfer_word(8'h5A, sw);
      for (int i = 0; i < 5; i++) xfer_bit(1'b1, b);
      rising = 1; falling = 1;
      @(posedge clk); #1;
      rising = 0; falling = 0;
      @(posedge clk); #1;
      sel = 0;
      @(posedge clk);
      @(negedge clk);
      chk("t5_abort", frame_abort, 1'b1);
      chk("t5_busy", busy, 1'b0);
      chk("t5_rx_data", rx_data, 8'h5A);
      chk("t5_wc", word_count, 8'd1);
      @(posedge clk); #1;
      repeat (3) @(posedge clk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/spi_slave_shift_engine.md
Name: spi_slave_shift_engine

Overview:
- Parametrised SPI slave shift engine for multi-word bursts within one chip-select window.
- Separate RX and TX shift registers; runtime-selectable CPOL/CPHA and bit order.
- One-deep TX holding register with valid/ready handshake; RX word strobe.
- Sits behind the SCLK edge detector (consumes `rising`/`falling` strobes) and in front of the register-file/command decoder.

Parameters:
- N, 8, word width in bits (N >= 2).
- WCW, 8, width of the per-frame word counter (saturates).
- IDLE_PATTERN, {N{1'b1}}, word transmitted when the TX holding register is empty at a load point.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- sel  in  1  chip select, active-high, already synchronised to clk.
- rising  in  1  one-clk strobe on SCLK rising edge (already synchronised).
- falling  in  1  one-clk strobe on SCLK falling edge.
- si  in  1  serial data in (MOSI), synchronised.
- so  out  1  serial data out (MISO).
- cpol  in  1  clock polarity; captured at sel rise.
- cpha  in  1  clock phase; captured at sel rise.
- lsb_first  in  1  bit order; captured at sel rise.
- tx_data  in  N  next word to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  holding register empty.
- rx_data  out  N  last complete received word.
- rx_valid  out  1  one-clk strobe when rx_data updates.
- word_count  out  WCW  complete words received in the current frame.
- busy  out  1  1 while a frame is active.
- tx_underrun  out  1  sticky; IDLE_PATTERN was sent; cleared at sel rise.
- frame_abort  out  1  one-clk strobe when sel falls mid-word.

Behaviour:
- Reset values:
  - so=0, tx_ready=1, rx_data=0, rx_valid=0, word_count=0, busy=0, tx_underrun=0, frame_abort=0.
  - Internal: shift registers and counters 0; holding register empty; state IDLE.
- sel_d is a registered copy of sel. sel rise = sel & ~sel_d; sel fall = ~sel & sel_d.
- Edge mapping:
  - lead = cpol ? falling : rising; trail = the opposite strobe.
  - CPHA=0: sample on lead, shift on trail. CPHA=1: sample on trail, shift on lead.
- State machine: IDLE, ACTIVE.
- IDLE -> ACTIVE on sel rise:
  - Latch cpol/cpha/lsb_first.
  - Clear bit counters, word_count and tx_underrun.
  - CPHA=0 only: perform a TX load in the same cycle.
- ACTIVE -> IDLE on sel fall:
  - If rx bit counter != 0, pulse frame_abort and discard the partial word; rx_data is not updated.
  - The holding register is kept.
- TX load:
  - tx_sr <= holding if full (holding becomes empty), else IDLE_PATTERN and tx_underrun <= 1.
  - Load points:
    - CPHA=0: sel rise, and the shift edge on which tx bit counter = N-1.
    - CPHA=1: every shift edge with tx bit counter = 0.
  - All other shift edges shift tx_sr by one toward the output bit.
  - The tx bit counter increments modulo N on each shift edge.
- so = lsb_first ? tx_sr[0] : tx_sr[N-1]. so is 0 in IDLE.
- RX sample edge:
  - MSB-first shifts si into bit 0; LSB-first shifts si into bit N-1.
  - On the Nth sample: rx_data <= assembled word (including the current si), rx_valid=1 next cycle, counter wraps to 0, word_count++ (saturating at all-ones).
- Holding register:
  - Accepts when tx_valid & tx_ready.
  - A same-cycle accept and load is allowed: load takes the new tx_data, and the holding register stays empty.
- Latency: rx_valid is asserted 1 clk after the sampling strobe.
- No RX backpressure: a consumer must take rx_data within N SCLK periods.
- Edge strobes are ignored in IDLE.
- rising & falling together: treated as a protocol error; both are ignored.
- busy = (state == ACTIVE).

Decomposition:
- Shared package:
  - Mode encoding constants (MODE0..MODE3 as {cpol,cpha}).
  - Default IDLE_PATTERN.
  - Counter width function clog2(N).
- One sub-module is natural: spi_tx_holding (one-deep valid/ready register with load/consume port).
- The RX/TX shift logic stays in the top module.

Test Plan:
1. Reset low mid-frame -> all outputs at reset values; tx_ready=1; next sel rise starts a clean frame.
2. Mode 0, MSB-first, N=8: tx_data=0xA5 preloaded, master sends 0x3C -> so bits 1,0,1,0,0,1,0,1; rx_data=0x3C, rx_valid one clk, word_count=1.
3. Mode 3, LSB-first: 3-word burst; tx words 0x01, 0x80, 0xFF written as tx_ready rises -> so streams correctly; rx_valid three times; word_count=3; tx_underrun=0.
4. Holding empty at second load point -> second word on so = 0xFF; tx_underrun=1 until the next sel rise.
5. sel deasserted after 5 bits -> frame_abort pulse; rx_data unchanged; busy=0; word_count holds the completed words.
6. tx_valid asserted in the same clk as a load point with holding empty -> that word is transmitted immediately; tx_ready stays 1.
